// File: rtl/spi_pkg.sv
// Shared types and constants for the write-only SPI byte serializer.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // CS stays low for this many half-periods past the final falling SCLK edge.
    localparam logic [3:0] HOLD_TICKS = 4'd2;

endpackage

// File: rtl/spi_byte_tx_if.sv
// Byte stream handshake between the command sequencer and the SPI serializer.
interface spi_byte_tx_if;

    logic [7:0] data;
    logic       dc;
    logic       last;
    logic       valid;
    logic       ready;

    modport master (output data, dc, last, valid, input ready);
    modport slave  (input data, dc, last, valid, output ready);

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode 0 byte serializer, MSB first; CS held low across a burst until a last byte.
module spi_byte_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spi_byte_tx_if.slave         up,
    output logic                 o_clk,
    output logic                 o_mosi,
    output logic                 o_cs,
    output logic                 o_dc,
    output logic                 o_busy
);

    localparam int unsigned GW = $clog2(CS_GAP + 1);

    state_e          state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [3:0]      half_q, half_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            last_q, last_d;
    logic            cs_q, cs_d;
    logic            clk_q, clk_d;
    logic            mosi_q, mosi_d;
    logic            dc_q, dc_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            accept;
    logic            tick;

    assign accept = up.valid && ready_q;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .en    ((state_q == StShift) || (state_q == StHold)),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        half_d  = half_q;
        gap_d   = gap_q;
        last_d  = last_q;
        cs_d    = cs_q;
        clk_d   = clk_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    shreg_d = {up.data[6:0], 1'b0};
                    mosi_d  = up.data[7];
                    dc_d    = up.dc;
                    last_d  = up.last;
                    cs_d    = 1'b0;
                    half_d  = '0;
                end
            end
            StShift: begin
                if (tick) begin
                    clk_d = ~clk_q;
                    if (half_q == 4'd15) begin
                        state_d = last_q ? StHold : StIdle;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + 4'd1;
                        // Next bit goes out on the falling edge only.
                        if (clk_q) begin
                            mosi_d  = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    if (half_q == HOLD_TICKS - 4'd1) begin
                        state_d = StGap;
                        cs_d    = 1'b1;
                        gap_d   = '0;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + 4'd1;
                    end
                end
            end
            StGap: begin
                if (gap_q == GW'(CS_GAP - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            half_q  <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            clk_q   <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= DC_CMD;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            clk_q   <= clk_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign up.ready = ready_q;
    assign o_clk    = clk_q;
    assign o_mosi   = mosi_q;
    assign o_cs     = cs_q;
    assign o_dc     = dc_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Bench for spi_byte_tx: timeline model of the waveform, SPI slave scoreboards, directed cases.
module tb_spi_byte_tx;

    localparam int DA = 2;
    localparam int GA = 4;
    localparam int SH = 16 * DA;
    localparam int HL = 2 * DA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    spi_byte_tx_if ifa ();
    spi_byte_tx_if ifb ();

    logic sclk_a, mosi_a, cs_a, dc_a, busy_a;
    logic sclk_b, mosi_b, cs_b, dc_b, busy_b;

    spi_byte_tx #(.CLK_DIV(2), .CS_GAP(4)) dut_a (
        .i_clk (clk), .i_rst (rst), .up (ifa),
        .o_clk (sclk_a), .o_mosi (mosi_a), .o_cs (cs_a), .o_dc (dc_a), .o_busy (busy_a)
    );

    spi_byte_tx #(.CLK_DIV(1), .CS_GAP(4)) dut_b (
        .i_clk (clk), .i_rst (rst), .up (ifb),
        .o_clk (sclk_b), .o_mosi (mosi_b), .o_cs (cs_b), .o_dc (dc_b), .o_busy (busy_b)
    );

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    bit edge_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) edge_seen <= 1'b0;
        else      edge_seen <= 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model for DUT A: outputs as a function of cycles since the last accept.
    bit         have = 1'b0;
    int         t_acc = 0;
    logic [7:0] md = 8'h00;
    logic       mdc = 1'b0;
    logic       mlast = 1'b0;
    logic [8:0] acc_q[$];

    always @(negedge clk) begin
        logic e_cs, e_clk, e_mosi, e_dc, e_busy, e_ready;
        int k, h;
        e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_dc = 1'b0; e_busy = 1'b0;
        e_ready = 1'b0;
        if (!rst) begin
            have = 1'b0;
        end else begin
            e_ready = edge_seen;
            if (have) begin
                k = cyc - t_acc;
                e_cs = 1'b0; e_dc = mdc; e_mosi = md[0];
                if (k <= SH) begin
                    h = (k - 1) / DA;
                    e_clk = 1'(h % 2);
                    e_mosi = md[7 - h / 2];
                    e_busy = 1'b1; e_ready = 1'b0;
                end else if (mlast) begin
                    if (k <= SH + HL) begin
                        e_busy = 1'b1; e_ready = 1'b0;
                    end else if (k <= SH + HL + GA) begin
                        e_cs = 1'b1; e_busy = 1'b1; e_ready = 1'b0;
                    end else begin
                        e_cs = 1'b1;
                    end
                end
            end
        end
        check("a_cs", int'(cs_a), int'(e_cs));
        check("a_sclk", int'(sclk_a), int'(e_clk));
        check("a_mosi", int'(mosi_a), int'(e_mosi));
        check("a_dc", int'(dc_a), int'(e_dc));
        check("a_busy", int'(busy_a), int'(e_busy));
        check("a_ready", int'(ifa.ready), int'(e_ready));
        if (rst && ifa.valid && e_ready) begin
            have = 1'b1; t_acc = cyc; md = ifa.data; mdc = ifa.dc; mlast = ifa.last;
            acc_q.push_back({ifa.dc, ifa.data});
        end
    end

    // SPI slave models sample MOSI/DC at each rising SCLK; partial bytes die on CS rise.
    logic [8:0] rx_a[$];
    logic [8:0] rx_b[$];
    int         rise_cyc_b[$];
    logic [7:0] sh_a = 8'h00, sh_b = 8'h00;
    int bc_a = 0, bc_b = 0, rises_a = 0, cs_rises_a = 0;
    int cs_rise_cyc_a = 0, ready_rise_cyc_a = 0, dc_rise_cyc_a = 0;
    logic pa_clk = 1'b0, pa_cs = 1'b1, pa_ready = 1'b0, pa_dc = 1'b0;
    logic pb_clk = 1'b0, pb_cs = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            bc_a = 0; pa_clk = 1'b0; pa_cs = 1'b1; pa_ready = 1'b0; pa_dc = 1'b0;
        end else begin
            if (sclk_a && !pa_clk) begin
                sh_a = {sh_a[6:0], mosi_a};
                bc_a++; rises_a++;
                if (bc_a == 8) begin
                    rx_a.push_back({dc_a, sh_a});
                    bc_a = 0;
                end
            end
            if (cs_a && !pa_cs) begin
                cs_rises_a++; cs_rise_cyc_a = cyc; bc_a = 0;
            end
            if (ifa.ready && !pa_ready) ready_rise_cyc_a = cyc;
            if (dc_a && !pa_dc) dc_rise_cyc_a = cyc;
            pa_clk = sclk_a; pa_cs = cs_a; pa_ready = ifa.ready; pa_dc = dc_a;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bc_b = 0; pb_clk = 1'b0; pb_cs = 1'b1;
        end else begin
            if (sclk_b && !pb_clk) begin
                sh_b = {sh_b[6:0], mosi_b};
                bc_b++;
                rise_cyc_b.push_back(cyc);
                if (bc_b == 8) begin
                    rx_b.push_back({dc_b, sh_b});
                    bc_b = 0;
                end
            end
            if (cs_b && !pb_cs) bc_b = 0;
            pb_clk = sclk_b; pb_cs = cs_b;
        end
    end

    // Call at a cycle start; returns just after the accepting edge.
    task automatic send(input bit sel, input logic [7:0] d, input logic dc, input logic l,
                        input bit keep, output int acc);
        int n = 0;
        if (sel) begin
            ifb.data = d; ifb.dc = dc; ifb.last = l; ifb.valid = 1'b1;
        end else begin
            ifa.data = d; ifa.dc = dc; ifa.last = l; ifa.valid = 1'b1;
        end
        @(negedge clk);
        while (!(sel ? ifb.ready : ifa.ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", int'(sel ? ifb.ready : ifa.ready), 1);
        acc = cyc;
        @(posedge clk);
        #2;
        if (!keep) begin
            if (sel) ifb.valid = 1'b0;
            else     ifa.valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        @(negedge clk);
        while (((sel ? busy_b : busy_a) || !(sel ? ifb.ready : ifa.ready)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", int'(sel ? ifb.ready : ifa.ready), 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, base_r, base_cs, n;
        ifa.valid = 1'b0; ifa.data = 8'h00; ifa.dc = 1'b0; ifa.last = 1'b0;
        ifb.valid = 1'b0; ifb.data = 8'h00; ifb.dc = 1'b0; ifb.last = 1'b0;
        #1 rst = 1'b0;

        // Reset and release.
        repeat (3) @(negedge clk);
        check("t1_cs_in_reset", int'(cs_a), 1);
        check("t1_sclk_in_reset", int'(sclk_a), 0);
        check("t1_ready_in_reset", int'(ifa.ready), 0);
        #3 rst = 1'b1;
        #2 check("t1_ready_before_edge", int'(ifa.ready), 0);
        @(negedge clk);
        check("t1_ready_after_edge", int'(ifa.ready), 1);
        check("t1_cs_idle", int'(cs_a), 1);
        @(posedge clk);
        #2;

        // Single command byte with last.
        base_r = rises_a; base_cs = cs_rises_a;
        rx_a.delete(); acc_q.delete();
        send(1'b0, 8'h2A, 1'b0, 1'b1, 1'b0, t1);
        wait_idle(1'b0);
        check("t2_cs_rise_offset", cs_rise_cyc_a - t1, 37);
        check("t2_ready_offset", ready_rise_cyc_a - t1, 41);
        check("t2_sclk_rises", rises_a - base_r, 8);
        check("t2_cs_rises", cs_rises_a - base_cs, 1);
        check("t2_rx_size", rx_a.size(), 1);
        if (rx_a.size() > 0) check("t2_rx_byte", int'(rx_a[0]), 'h02A);

        // Burst: command then data, valid held.
        base_r = rises_a; base_cs = cs_rises_a;
        rx_a.delete(); acc_q.delete();
        send(1'b0, 8'h2C, 1'b0, 1'b0, 1'b1, t1);
        send(1'b0, 8'h12, 1'b1, 1'b1, 1'b0, t2);
        wait_idle(1'b0);
        check("t3_second_accept", t2 - t1, 33);
        check("t3_dc_switch", dc_rise_cyc_a - t1, 34);
        check("t3_sclk_rises", rises_a - base_r, 16);
        check("t3_cs_rises", cs_rises_a - base_cs, 1);
        check("t3_rx_size", rx_a.size(), 2);
        if (rx_a.size() > 1) begin
            check("t3_rx_byte0", int'(rx_a[0]), 'h02C);
            check("t3_rx_byte1", int'(rx_a[1]), 'h112);
        end

        // Random valid with churning payload.
        rx_a.delete(); acc_q.delete();
        for (int i = 0; i < 400; i++) begin
            ifa.valid = 1'($urandom_range(0, 1));
            ifa.data = 8'($urandom);
            ifa.dc = 1'($urandom_range(0, 1));
            ifa.last = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        ifa.valid = 1'b0;
        wait_idle(1'b0);
        check("t4_byte_count", rx_a.size(), acc_q.size());
        for (int i = 0; i < acc_q.size() && i < rx_a.size(); i++)
            check("t4_byte", int'(rx_a[i]), int'(acc_q[i]));

        // Reset after the 4th rising SCLK edge, then a clean 0xFF.
        base_r = rises_a;
        send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, t1);
        n = 0;
        while (rises_a - base_r < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_4th_rise", rises_a - base_r, 4);
        #3 rst = 1'b0;
        #1;
        check("t5_cs_async", int'(cs_a), 1);
        check("t5_sclk_async", int'(sclk_a), 0);
        check("t5_busy_async", int'(busy_a), 0);
        check("t5_ready_async", int'(ifa.ready), 0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        rx_a.delete(); acc_q.delete();
        @(posedge clk);
        #2;
        base_r = rises_a;
        send(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, t1);
        wait_idle(1'b0);
        check("t5_rx_size", rx_a.size(), 1);
        if (rx_a.size() > 0) check("t5_rx_ff", int'(rx_a[0]), 'h1FF);
        check("t5_sclk_rises", rises_a - base_r, 8);

        // CLK_DIV=1 instance: back-to-back 0x81 bytes.
        rx_b.delete(); rise_cyc_b.delete();
        send(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, t1);
        send(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, t2);
        wait_idle(1'b1);
        check("t6_b2b_spacing", t2 - t1, 17);
        check("t6_sclk_rises", rise_cyc_b.size(), 16);
        if (rise_cyc_b.size() > 1)
            check("t6_sclk_period", rise_cyc_b[1] - rise_cyc_b[0], 2);
        check("t6_rx_size", rx_b.size(), 2);
        if (rx_b.size() > 1) begin
            check("t6_rx_byte0", int'(rx_b[0]), 'h081);
            check("t6_rx_byte1", int'(rx_b[1]), 'h181);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
